tophat_pred_buffer: RTL
=======================

TOPHAT_PRED_BUFFER -- requirements
Module: tophat_pred_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of prediction entries; power of two, 2..8.
REQ-002 SHALL have parameter DATA_W, default 8: prediction value width.
REQ-003 SHALL have clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have clear_i, input, 1: flush entries and sticky flags; same pulse that clears the tree core.
REQ-006 SHALL have pred_valid_i, input, 1: push request, one cycle per prediction from the tree core.
REQ-007 SHALL have pred_value_i, input, DATA_W: prediction value to store.
REQ-008 SHALL have error_i, input, 1: core error flag, stored alongside the value.
REQ-009 SHALL have pop_i, input, 1: host acknowledges the head entry.
REQ-010 SHALL have head_valid_o, output, 1: buffer non-empty; head fields meaningful.
REQ-011 SHALL have head_value_o, output, DATA_W: oldest stored value.
REQ-012 SHALL have head_error_o, output, 1: error bit of the oldest entry.
REQ-013 SHALL have count_o, output, clog2(DEPTH)+1: occupied entries.
REQ-014 SHALL have full_o, output, 1: count_o == DEPTH.
REQ-015 SHALL have overflow_o, output, 1: sticky; a push was dropped.
REQ-016 SHALL have total_o, output, 8: saturating count of accepted pushes since reset/clear.

Function
REQ-017 SHALL be a circular FIFO: write pointer, read pointer and occupancy counter, pointers wrapping modulo DEPTH.
REQ-018 SHALL accept a push on a cycle with pred_valid_i=1 and (count<DEPTH or pop_i accepted that cycle).
REQ-019 SHALL accept a pop on a cycle with pop_i=1 and count>0; a pop when empty SHALL be ignored with no state change.
REQ-020 SHALL apply a simultaneous accepted push and pop together: count unchanged, both pointers advance.
REQ-021 SHALL apply push and pop together when full: push accepted, no overflow.
REQ-022 SHALL apply push and pop together when empty: pop ignored, push accepted, count becomes 1.
REQ-023 SHALL drop a push when full without a pop, leave contents unchanged, and set overflow_o from the next cycle.
REQ-024 SHALL give latency 1: data pushed at edge N is visible on head_* and count_o after edge N.
REQ-025 SHALL drive head_* from the read-pointer entry; head_value_o/head_error_o SHALL be 0 when empty.
REQ-026 SHALL increment total_o on each accepted push, saturating at 255 with no wrap.
REQ-027 SHALL give clear_i priority over push/pop in the same cycle: count, pointers, overflow_o and total_o go to 0; the push that cycle is discarded.
REQ-028 SHALL hold overflow_o until rst or clear_i.

Reset
REQ-029 SHALL on rst=1 at an edge set pointers, count_o, total_o, overflow_o, head_valid_o, head_value_o and head_error_o to 0, and full_o to 0.
REQ-030 SHALL give rst priority over clear_i, push and pop; reset mid-stream discards all entries.
REQ-031 SHALL need no reset for the entry storage array; empty-state output gating alone keeps outputs defined.

Structure
REQ-032 SHALL take DEPTH/DATA_W defaults and the total_o width/saturation constant from shared package tophat_pkg.
REQ-033 SHALL be one module with no sub-module; storage is an inferred register array.

Verification
REQ-034 SHALL check: push values 0x11, 0x22, 0x33 on consecutive cycles -> count_o=3; pops return 0x11, 0x22, 0x33 in order; head_valid_o drops after the third pop.
REQ-035 SHALL check: five pushes with DEPTH=4 and no pops -> full_o=1, overflow_o=1, count_o=4, total_o=4; the fifth value is absent from the pops.
REQ-036 SHALL check: when full, push 0x55 and pop in the same cycle -> count_o stays 4, overflow_o=0, 0x55 is read last.
REQ-037 SHALL check: when empty, push 0x7F with error_i=1 and pop in the same cycle -> the next cycle shows head_valid_o=1, head_value_o=0x7F, head_error_o=1.
REQ-038 SHALL check: clear_i asserted with a push in the same cycle when 2 entries are held -> count_o=0, total_o=0, overflow_o=0.
REQ-039 SHALL check: 300 push/pop pairs -> total_o=255; after rst all outputs are 0.

Source files
------------

// File: rtl/tophat_pkg.sv
// Shared sizing for the tophat prediction path: buffer defaults and the
// saturating accepted-push counter used by tophat_pred_buffer.
package tophat_pkg;

  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 8;

  localparam int unsigned          TOTAL_W   = 8;
  localparam logic [TOTAL_W-1:0]   TOTAL_MAX = 8'hFF;

  function automatic logic [TOTAL_W-1:0] sat_inc(input logic [TOTAL_W-1:0] v);
    return (v == TOTAL_MAX) ? v : v + TOTAL_W'(1);
  endfunction

endpackage

// File: rtl/tophat_pred_buffer.sv
// Circular FIFO of {error, value} predictions from the tree core to the host.
// Latency 1: a push at edge N shows on head_* and count_o right after edge N.
// No backpressure: a push while full without a pop is dropped and sticks overflow_o.
module tophat_pred_buffer
  import tophat_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       pred_valid_i,
  input  logic [DATA_W-1:0]          pred_value_i,
  input  logic                       error_i,
  input  logic                       pop_i,
  output logic                       head_valid_o,
  output logic [DATA_W-1:0]          head_value_o,
  output logic                       head_error_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       overflow_o,
  output logic [TOTAL_W-1:0]         total_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W:0]      mem_q [DEPTH];
  logic [DATA_W:0]      mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic                 push_acc, pop_acc;

  always_comb begin
    pop_acc    = pop_i && (count_q != '0);
    // A pop on the same edge frees the slot, so a full buffer still takes the push.
    push_acc   = pred_valid_i && ((count_q < CNT_W'(DEPTH)) || pop_acc);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    total_d    = total_q;

    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      total_d    = '0;
    end else begin
      if (push_acc) begin
        mem_d[wr_ptr_q] = {error_i, pred_value_i};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        total_d         = sat_inc(total_q);
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (pred_valid_i && !push_acc) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      total_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      total_q    <= total_d;
    end
  end

  // Storage is never reset; head outputs are gated by occupancy instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head_valid_o = (count_q != '0);
    head_value_o = head_valid_o ? mem_q[rd_ptr_q][DATA_W-1:0] : '0;
    head_error_o = head_valid_o ? mem_q[rd_ptr_q][DATA_W]     : 1'b0;
    count_o      = count_q;
    full_o       = (count_q == CNT_W'(DEPTH));
    overflow_o   = overflow_q;
    total_o      = total_q;
  end

endmodule
